// File: rtl/fir_filter_tap_sequencer_if.sv
// Sample handshake and tap/coeff RAM control bundle for fir_filter_tap_sequencer.
// Build with FIR_SEQ_DECIM_EN to add the decimation factor input.
interface fir_filter_tap_sequencer_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  sample_valid_in;
  logic [DATA_WIDTH-1:0] sample_data_in;
  logic                  sample_ready_out;
  logic                  tap_wr_en_out;
  logic [ADDR_WIDTH-1:0] tap_wr_addr_out;
  logic [DATA_WIDTH-1:0] tap_wr_data_out;
  logic [ADDR_WIDTH-1:0] tap_rd_addr_out;
  logic [ADDR_WIDTH-1:0] coeff_rd_addr_out;
  logic                  mult_en_out;
  logic                  overwrite_out;
  logic                  output_valid_out;
  logic                  busy_out;
`ifdef FIR_SEQ_DECIM_EN
  logic [7:0]            decim_factor_in;

  // Sequencer side: drives RAM control and mult-stage flags.
  modport master (
    input  sample_valid_in, sample_data_in, decim_factor_in,
    output sample_ready_out, tap_wr_en_out, tap_wr_addr_out, tap_wr_data_out,
           tap_rd_addr_out, coeff_rd_addr_out, mult_en_out, overwrite_out,
           output_valid_out, busy_out
  );

  modport slave (
    output sample_valid_in, sample_data_in, decim_factor_in,
    input  sample_ready_out, tap_wr_en_out, tap_wr_addr_out, tap_wr_data_out,
           tap_rd_addr_out, coeff_rd_addr_out, mult_en_out, overwrite_out,
           output_valid_out, busy_out
  );
`else
  // Sequencer side: drives RAM control and mult-stage flags.
  modport master (
    input  sample_valid_in, sample_data_in,
    output sample_ready_out, tap_wr_en_out, tap_wr_addr_out, tap_wr_data_out,
           tap_rd_addr_out, coeff_rd_addr_out, mult_en_out, overwrite_out,
           output_valid_out, busy_out
  );

  modport slave (
    output sample_valid_in, sample_data_in,
    input  sample_ready_out, tap_wr_en_out, tap_wr_addr_out, tap_wr_data_out,
           tap_rd_addr_out, coeff_rd_addr_out, mult_en_out, overwrite_out,
           output_valid_out, busy_out
  );
`endif
endinterface

// File: rtl/fir_filter_tap_sequencer.sv
// Time-multiplexed tap/coeff address sequencer for a single-multiplier FIR datapath.
// Optional decimation (issue only every Nth sample) is enabled by defining FIR_SEQ_DECIM_EN.
module fir_filter_tap_sequencer #(
  parameter int NUM_TAPS   = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  fir_filter_tap_sequencer_if.master bus
);

  localparam int CLR_WIDTH = $clog2(NUM_TAPS + 1);
  localparam logic [CLR_WIDTH-1:0]  CLR_DONE  = CLR_WIDTH'(NUM_TAPS);
  localparam logic [ADDR_WIDTH-1:0] LAST_TAP  = ADDR_WIDTH'(NUM_TAPS - 1);
  localparam logic [ADDR_WIDTH:0]   WIDE_TAPS = (ADDR_WIDTH + 1)'(NUM_TAPS);

  typedef enum logic [1:0] {CLEAR, IDLE, WRITE, ISSUE} state_t;

  state_t                state;
  logic [CLR_WIDTH-1:0]  clr_cnt;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] k;
  logic                  ready_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [ADDR_WIDTH-1:0] coeff_addr_q;
  logic                  mult_en_q;
  logic                  overwrite_q;
  logic                  output_valid_q;

`ifdef FIR_SEQ_DECIM_EN
  logic [7:0] dcnt;
  logic [7:0] decim_factor;
  logic       do_issue;

  assign decim_factor = (bus.decim_factor_in <= 8'd1) ? 8'd1 : bus.decim_factor_in;
`endif

  // Newest-first tap walk; the wide sum keeps ptr+NUM_TAPS from overflowing when 2**ADDR_WIDTH == NUM_TAPS.
  function automatic logic [ADDR_WIDTH-1:0] tap_addr(input logic [ADDR_WIDTH-1:0] ptr,
                                                     input logic [ADDR_WIDTH-1:0] idx);
    logic [ADDR_WIDTH:0] wide;
    if (idx > ptr) wide = {1'b0, ptr} + WIDE_TAPS - {1'b0, idx};
    else           wide = {1'b0, ptr} - {1'b0, idx};
    return wide[ADDR_WIDTH-1:0];
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] ptr);
    return (ptr == LAST_TAP) ? '0 : ptr + ADDR_WIDTH'(1);
  endfunction

  // Outputs are registered for the cycle the FSM is entering; flags trail their address cycle by one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= CLEAR;
      clr_cnt        <= '0;
      wr_ptr         <= '0;
      k              <= '0;
      ready_q        <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      rd_addr_q      <= '0;
      coeff_addr_q   <= '0;
      mult_en_q      <= 1'b0;
      overwrite_q    <= 1'b0;
      output_valid_q <= 1'b0;
`ifdef FIR_SEQ_DECIM_EN
      dcnt           <= '0;
      do_issue       <= 1'b0;
`endif
    end else begin
      mult_en_q      <= (state == ISSUE);
      overwrite_q    <= (state == ISSUE) && (k == '0);
      output_valid_q <= (state == ISSUE) && (k == LAST_TAP);

      case (state)
        CLEAR: begin
          if (clr_cnt == CLR_DONE) begin
            wr_en_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= ADDR_WIDTH'(clr_cnt);
            wr_data_q <= '0;
            clr_cnt   <= clr_cnt + CLR_WIDTH'(1);
          end
        end

        IDLE: begin
          if (bus.sample_valid_in && ready_q) begin
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b1;
            wr_addr_q <= wr_ptr;
            wr_data_q <= bus.sample_data_in;
            state     <= WRITE;
`ifdef FIR_SEQ_DECIM_EN
            do_issue  <= (dcnt == 8'd0);
            dcnt      <= (dcnt >= decim_factor - 8'd1) ? 8'd0 : dcnt + 8'd1;
`endif
          end
        end

        WRITE: begin
          wr_en_q <= 1'b0;
`ifdef FIR_SEQ_DECIM_EN
          if (do_issue) begin
            k            <= '0;
            rd_addr_q    <= wr_ptr;
            coeff_addr_q <= '0;
            state        <= ISSUE;
          end else begin
            wr_ptr  <= next_ptr(wr_ptr);
            ready_q <= 1'b1;
            state   <= IDLE;
          end
`else
          k            <= '0;
          rd_addr_q    <= wr_ptr;
          coeff_addr_q <= '0;
          state        <= ISSUE;
`endif
        end

        ISSUE: begin
          if (k == LAST_TAP) begin
            wr_ptr  <= next_ptr(wr_ptr);
            ready_q <= 1'b1;
            state   <= IDLE;
          end else begin
            k            <= k + ADDR_WIDTH'(1);
            coeff_addr_q <= k + ADDR_WIDTH'(1);
            rd_addr_q    <= tap_addr(wr_ptr, k + ADDR_WIDTH'(1));
          end
        end

        default: state <= CLEAR;
      endcase
    end
  end

  assign bus.sample_ready_out  = ready_q;
  assign bus.tap_wr_en_out     = wr_en_q;
  assign bus.tap_wr_addr_out   = wr_addr_q;
  assign bus.tap_wr_data_out   = wr_data_q;
  assign bus.tap_rd_addr_out   = rd_addr_q;
  assign bus.coeff_rd_addr_out = coeff_addr_q;
  assign bus.mult_en_out       = mult_en_q;
  assign bus.overwrite_out     = overwrite_q;
  assign bus.output_valid_out  = output_valid_q;
  assign bus.busy_out          = (state != IDLE) || mult_en_q || overwrite_q || output_valid_q;

endmodule

// File: tb/tb_fir_filter_tap_sequencer.sv
// Directed bench for fir_filter_tap_sequencer at NUM_TAPS=4, ADDR_WIDTH=2.
// Define FIR_SEQ_DECIM_EN to also exercise the decimation path.
module tb_fir_filter_tap_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   ov_count;
  int   ov_start;

  fir_filter_tap_sequencer_if #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) bus ();

  fir_filter_tap_sequencer #(
    .NUM_TAPS  (4),
    .ADDR_WIDTH(2),
    .DATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Counts output_valid pulses independently of the directed checks.
  always @(posedge clk) begin
    if (bus.output_valid_out) ov_count <= ov_count + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyClear();
    for (int i = 0; i < 4; i++) begin
      step();
      check("clr_wr_en", bus.tap_wr_en_out, 1);
      check("clr_wr_addr", bus.tap_wr_addr_out, i);
      check("clr_wr_data", bus.tap_wr_data_out, 0);
      check("clr_ready", bus.sample_ready_out, 0);
      check("clr_busy", bus.busy_out, 1);
    end
    step();
    check("clr_done_ready", bus.sample_ready_out, 1);
    check("clr_done_wr_en", bus.tap_wr_en_out, 0);
    check("clr_done_busy", bus.busy_out, 0);
  endtask

  // Entered in an IDLE cycle; leaves in the IDLE cycle that carries output_valid.
  task automatic runSample(input logic [31:0] data, input int ptr, input bit hold,
                           input logic [31:0] next_data);
    check("idle_ready", bus.sample_ready_out, 1);
    bus.sample_valid_in = 1'b1;
    bus.sample_data_in  = data;
    step();
    check("write_en", bus.tap_wr_en_out, 1);
    check("write_addr", bus.tap_wr_addr_out, ptr);
    check("write_data", bus.tap_wr_data_out, data);
    check("write_ready", bus.sample_ready_out, 0);
    if (hold) begin
      bus.sample_valid_in = 1'b1;
      bus.sample_data_in  = next_data;
    end else begin
      bus.sample_valid_in = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      step();
      check("issue_tap_rd", bus.tap_rd_addr_out, (ptr + 4 - k) % 4);
      check("issue_coeff_rd", bus.coeff_rd_addr_out, k);
      check("issue_mult_en", bus.mult_en_out, (k != 0) ? 1 : 0);
      check("issue_overwrite", bus.overwrite_out, (k == 1) ? 1 : 0);
      check("issue_output_valid", bus.output_valid_out, 0);
      check("issue_wr_en", bus.tap_wr_en_out, 0);
      check("issue_ready", bus.sample_ready_out, 0);
    end
    step();
    check("last_ready", bus.sample_ready_out, 1);
    check("last_mult_en", bus.mult_en_out, 1);
    check("last_output_valid", bus.output_valid_out, 1);
    check("last_overwrite", bus.overwrite_out, 0);
    check("last_busy", bus.busy_out, 1);
    check("last_rd_hold", bus.tap_rd_addr_out, (ptr + 1) % 4);
    check("last_coeff_hold", bus.coeff_rd_addr_out, 3);
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    checks   = 0;
    failures = 0;
    ov_count = 0;
    bus.sample_valid_in = 1'b0;
    bus.sample_data_in  = '0;
`ifdef FIR_SEQ_DECIM_EN
    bus.decim_factor_in = 8'd1;
`endif

    $display("[TB] reset state");
    repeat (3) step();
    check("rst_wr_en", bus.tap_wr_en_out, 0);
    check("rst_ready", bus.sample_ready_out, 0);
    check("rst_mult_en", bus.mult_en_out, 0);
    check("rst_overwrite", bus.overwrite_out, 0);
    check("rst_output_valid", bus.output_valid_out, 0);
    check("rst_tap_rd", bus.tap_rd_addr_out, 0);
    check("rst_coeff_rd", bus.coeff_rd_addr_out, 0);
    check("rst_busy", bus.busy_out, 1);
    rst = 1'b0;
    applyClear();

    $display("[TB] single sample");
    runSample(32'hA5, 0, 1'b0, 32'h0);
    step();
    check("single_idle_mult_en", bus.mult_en_out, 0);
    check("single_idle_output_valid", bus.output_valid_out, 0);
    check("single_idle_busy", bus.busy_out, 0);

    $display("[TB] valid held during ISSUE");
    runSample(32'h11, 1, 1'b1, 32'h22);
    runSample(32'h22, 2, 1'b0, 32'h0);
    step();

    $display("[TB] reset during ISSUE");
    bus.sample_valid_in = 1'b1;
    bus.sample_data_in  = 32'h33;
    step();
    check("abort_write_addr", bus.tap_wr_addr_out, 3);
    bus.sample_valid_in = 1'b0;
    step();
    step();
    check("abort_second_issue_rd", bus.tap_rd_addr_out, 2);
    rst = 1'b1;
    ov_start = ov_count;
    step();
    check("abort_mult_en", bus.mult_en_out, 0);
    check("abort_overwrite", bus.overwrite_out, 0);
    check("abort_output_valid", bus.output_valid_out, 0);
    check("abort_wr_en", bus.tap_wr_en_out, 0);
    check("abort_ready", bus.sample_ready_out, 0);
    check("abort_busy", bus.busy_out, 1);
    step();
    rst = 1'b0;
    applyClear();
    check("abort_no_output_valid", ov_count - ov_start, 0);

    $display("[TB] five back-to-back samples");
    ov_start = ov_count;
    for (int i = 0; i < 5; i++) begin
      runSample(32'h100 + i, i % 4, (i < 4), 32'h100 + i + 1);
    end
    bus.sample_valid_in = 1'b0;
    step();
    check("burst_output_valid_pulses", ov_count - ov_start, 5);
    check("burst_idle_busy", bus.busy_out, 0);

`ifdef FIR_SEQ_DECIM_EN
    $display("[TB] decimation by 3");
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    applyClear();
    bus.decim_factor_in = 8'd3;
    ov_start = ov_count;
    for (int i = 0; i < 6; i++) begin
      check("decim_ready", bus.sample_ready_out, 1);
      bus.sample_valid_in = 1'b1;
      bus.sample_data_in  = 32'h200 + i;
      step();
      check("decim_wr_en", bus.tap_wr_en_out, 1);
      check("decim_wr_addr", bus.tap_wr_addr_out, i % 4);
      bus.sample_valid_in = 1'b0;
      if (i % 3 == 0) repeat (5) step();
      else step();
      check("decim_ready_back", bus.sample_ready_out, 1);
    end
    check("decim_output_valid_pulses", ov_count - ov_start, 2);
    bus.sample_valid_in = 1'b1;
    bus.sample_data_in  = 32'h2FF;
    step();
    check("decim_final_wr_ptr", bus.tap_wr_addr_out, 2);
    bus.sample_valid_in = 1'b0;
    repeat (6) step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_filter_tap_sequencer.md
Name: fir_filter_tap_sequencer

Overview:
- Time-multiplexed control for the FIR datapath. One multiply stage and one accumulator serve all NUM_TAPS taps.
- On each accepted input sample, the block:
  - writes the sample into an external circular tap-delay RAM;
  - walks NUM_TAPS tap/coefficient read address pairs;
  - drives the overwrite and output_valid flags of fir_filter_mult_stage, aligned with the RAM read data.
- Sits between the sample source and the tap/coeff RAMs feeding the mult stage.

Parameters:
- NUM_TAPS, 16, number of filter taps; any value >= 2, power of two not required.
- ADDR_WIDTH, 4, width of tap and coeff addresses; must satisfy 2**ADDR_WIDTH >= NUM_TAPS.
- DATA_WIDTH, 32, sample width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_valid_in  in  1  input sample valid.
- sample_data_in  in  DATA_WIDTH  input sample.
- sample_ready_out  out  1  sequencer can accept a sample.
- tap_wr_en_out  out  1  tap RAM write enable.
- tap_wr_addr_out  out  ADDR_WIDTH  tap RAM write address.
- tap_wr_data_out  out  DATA_WIDTH  tap RAM write data.
- tap_rd_addr_out  out  ADDR_WIDTH  tap RAM read address.
- coeff_rd_addr_out  out  ADDR_WIDTH  coefficient RAM read address.
- mult_en_out  out  1  tap_data/coeff_data at mult stage inputs are valid this cycle.
- overwrite_out  out  1  to mult_stage overwrite_in; first product of a sample.
- output_valid_out  out  1  to mult_stage output_valid_in; last product of a sample.
- busy_out  out  1  state != IDLE, or any flag still in the flag pipeline.

Behaviour:
- Reset:
  - Applies on the first clk edge with rst=1.
  - Sets state=CLEAR, clr_cnt=0, wr_ptr=0, k=0.
  - All outputs 0, except busy_out=1 once in CLEAR.
  - Reset mid-operation aborts the current sample: no output_valid_out for it, and flag registers are cleared.
- State machine: CLEAR -> IDLE -> WRITE -> ISSUE -> IDLE.
- CLEAR (NUM_TAPS cycles):
  - tap_wr_en_out=1, tap_wr_addr_out=clr_cnt, tap_wr_data_out=0.
  - clr_cnt counts 0..NUM_TAPS-1, then state goes to IDLE.
  - sample_ready_out=0.
- IDLE:
  - sample_ready_out=1.
  - On valid&&ready: register sample_data_in, go to WRITE.
  - valid without acceptance is ignored (no state change).
- WRITE (1 cycle):
  - tap_wr_en_out=1, tap_wr_addr_out=wr_ptr, tap_wr_data_out=registered sample.
  - Next state ISSUE with k=0.
- ISSUE (NUM_TAPS cycles, k=0..NUM_TAPS-1):
  - coeff_rd_addr_out=k.
  - tap_rd_addr_out=(wr_ptr-k) mod NUM_TAPS. Wrap is explicit: if k>wr_ptr, address = wr_ptr+NUM_TAPS-k.
  - On k=NUM_TAPS-1: wr_ptr <= (wr_ptr==NUM_TAPS-1)?0:wr_ptr+1, state <= IDLE.
- Read addresses hold their last value outside ISSUE.
- RAM read latency is 1 cycle. Flags are registered 1 cycle after their address cycle:
  - mult_en_out=1 for each ISSUE cycle.
  - overwrite_out=1 only for k=0.
  - output_valid_out=1 only for k=NUM_TAPS-1.
- Timing (sample accepted on cycle 0):
  - WRITE on cycle 1.
  - Addresses on cycles 2..NUM_TAPS+1.
  - mult_en_out on cycles 3..NUM_TAPS+2.
  - overwrite_out on cycle 3; output_valid_out on cycle NUM_TAPS+2.
- Throughput: one sample per NUM_TAPS+2 cycles. sample_ready_out returns to 1 on cycle NUM_TAPS+2.
- Back-to-back samples: a sample accepted on cycle NUM_TAPS+2 starts WRITE while output_valid_out of the previous sample is high. This is legal; the flag streams never overlap.
- Write-before-read: WRITE precedes ISSUE, so k=0 reads the newest sample.

Optional Feature:
- Macro: FIR_SEQ_DECIM_EN.
- With the macro:
  - Adds input decim_factor_in [7:0]; values 0 and 1 are treated as 1.
  - A decimation counter dcnt resets to 0.
  - Each accepted sample is always written (WRITE).
  - ISSUE runs only when dcnt==0. Otherwise the state goes WRITE -> IDLE and wr_ptr still advances.
  - dcnt increments per accepted sample, wrapping to 0 at factor-1.
  - decim_factor_in is sampled at each acceptance.
- Without the macro: every accepted sample is fully issued; the port is absent.

Test Plan (NUM_TAPS=4, ADDR_WIDTH=2):
- Release rst -> 4 CLEAR cycles, tap_wr addresses 0,1,2,3 with data 0; sample_ready_out=1 on cycle 5.
- Single sample 0xA5 in IDLE -> WRITE to addr 0; tap_rd 0,3,2,1 with coeff 0,1,2,3; overwrite_out on first mult_en_out; output_valid_out on fourth; wr_ptr=1.
- Five samples back-to-back with valid held high -> acceptance every 6 cycles. Fifth sample written to addr 0; its tap_rd sequence 0,3,2,1; exactly 5 output_valid_out pulses.
- rst asserted on second ISSUE cycle -> next cycle all flags 0, state CLEAR, wr_ptr=0; no output_valid_out for the aborted sample.
- sample_valid_in high during ISSUE -> sample_ready_out=0, no acceptance; sample taken in IDLE with data unchanged.
- FIR_SEQ_DECIM_EN with decim_factor_in=3, six samples -> six writes; ISSUE only for samples 1 and 4; two output_valid_out pulses; wr_ptr=2 at end.
